mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy length of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy length of div/divu.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port MDOp_EX  input  4  decoded op: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-006 SHALL have port Start_EX  input  1  instruction in EX is a mult/div start.
REQ-007 SHALL have port Flush_EX  input  1  EX instruction squashed by exception/interrupt this cycle.
REQ-008 SHALL have port SrcA_EX  input  32  forwarded rs operand.
REQ-009 SHALL have port SrcB_EX  input  32  forwarded rt operand.
REQ-010 SHALL have port Busy_MD  output  1  start accepted this cycle or operation in flight; used by hazard unit to stall MD-class instructions.
REQ-011 SHALL have port HI_out  output  32  architectural HI.
REQ-012 SHALL have port LO_out  output  32  architectural LO.
REQ-013 SHALL have port MDout_EX  output  32  HI_out for MFHI, LO_out for MFLO, else 0.

Function
REQ-014 SHALL implement states IDLE and BUSY with a down-counter cnt.
REQ-015 SHALL accept a start iff state==IDLE, Start_EX=1, Flush_EX=0, MDOp_EX in {MULT,MULTU,DIV,DIVU}.
REQ-016 SHALL, on the accept edge, latch the full 64-bit result into pending regs, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-017 SHALL compute MULT/DIV as signed and MULTU/DIVU as unsigned; product {HI,LO}; quotient to LO, remainder to HI; remainder takes the sign of the dividend.
REQ-018 SHALL decrement cnt each BUSY cycle; on the edge ending the cycle where cnt==1, write pending to HI/LO and return to IDLE.
REQ-019 SHALL therefore keep Busy_MD high for exactly N+1 cycles (start cycle plus N BUSY cycles), with new HI/LO visible on the cycle after Busy_MD falls.
REQ-020 SHALL assert Busy_MD combinationally = accept condition OR state==BUSY.
REQ-021 SHALL, on divide with divisor 0, run the full DIV_CYCLES but leave HI/LO unchanged at completion.
REQ-022 SHALL write SrcA_EX to HI (MTHI) or LO (MTLO) on the next edge only when state==IDLE and Flush_EX=0.
REQ-023 SHALL ignore Start_EX, MTHI and MTLO while BUSY (the hazard unit guarantees none arrive; the block is robust if one does).
REQ-024 SHALL let an in-flight operation complete regardless of Flush_EX; Flush_EX only suppresses the EX-cycle start/move.
REQ-025 SHALL return HI_out/LO_out for MFHI/MFLO when IDLE; during BUSY it returns the old values, because stalling prevents MF reads there.

Reset
REQ-026 SHALL on reset set state=IDLE, cnt=0, HI=0, LO=0, pending=0; Busy_MD=0 and MDout_EX=0 follow.
REQ-027 SHALL abort an in-flight operation on reset mid-operation with no HI/LO update, reset taking priority over completion on the same edge.

Structure
REQ-028 SHALL take MDOp encodings and default latency constants from shared package mdu_pkg.
REQ-029 SHALL place the combinational 64-bit multiply/divide in one sub-module md_calc; mdu_ctrl holds the FSM, counter and registers.

Verification
REQ-030 SHALL cover MULT A=3, B=0xFFFFFFFE -> Busy_MD high 6 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 SHALL cover DIVU 7/2 -> Busy_MD high 11 cycles, then LO=3, HI=1; DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 SHALL cover MTHI 0x1234 then DIV 5/0 -> full busy length, HI remains 0x1234, LO unchanged.
REQ-033 SHALL cover Start_EX=1 with Flush_EX=1 -> Busy_MD=0 on that cycle (combinational accept suppressed), no BUSY entry, HI/LO unchanged; MTLO with Flush_EX=1 -> LO unchanged.
REQ-034 SHALL cover reset asserted on BUSY cycle 3 of MULTU 0xFFFFFFFF*2 -> next cycle IDLE, HI=LO=0, Busy_MD=0.
REQ-035 SHALL cover a second MULT start while BUSY -> ignored; first result committed on schedule, no extra busy cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and small decode helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit multiply/divide datapath. Divide packs {remainder, quotient};
// a zero divisor is flagged so the controller can discard the result.
module md_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [31:0]        b_nz;
  logic signed [32:0] quo_s;
  logic signed [32:0] rem_s;

  // Signed divide is done at 33 bits so 0x80000000 / -1 cannot overflow the operator.
  assign div_zero = (b == 32'd0);
  assign b_nz     = div_zero ? 32'd1 : b;
  assign quo_s    = $signed({a[31], a}) / $signed({b_nz[31], b_nz});
  assign rem_s    = $signed({a[31], a}) % $signed({b_nz[31], b_nz});

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    result = '0;
    case (op)
      MD_MULT:  result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV:   result = {rem_s[31:0], quo_s[31:0]};
      MD_DIVU:  result = {a % b_nz, a / b_nz};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: IDLE/BUSY sequencer with a latency down-counter,
// pending result registers and the architectural HI/LO pair.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp_EX,
  input  logic        Start_EX,
  input  logic        Flush_EX,
  input  logic [31:0] SrcA_EX,
  input  logic [31:0] SrcB_EX,
  output logic        Busy_MD,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] MDout_EX
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        hi, lo;
  logic [31:0]        pend_hi, pend_lo;
  logic               pend_write;
  logic [63:0]        calc_result;
  logic               calc_div_zero;
  logic               accept;

  md_calc u_calc (
    .op       (MDOp_EX),
    .a        (SrcA_EX),
    .b        (SrcB_EX),
    .result   (calc_result),
    .div_zero (calc_div_zero)
  );

  assign accept  = (state == IDLE) && Start_EX && !Flush_EX && is_start_op(MDOp_EX);
  assign Busy_MD = accept || (state == BUSY);
  assign HI_out  = hi;
  assign LO_out  = lo;

  always_comb begin
    MDout_EX = '0;
    if (MDOp_EX == MD_MFHI)      MDout_EX = hi;
    else if (MDOp_EX == MD_MFLO) MDout_EX = lo;
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pend_hi    <= calc_result[63:32];
            pend_lo    <= calc_result[31:0];
            pend_write <= !(is_div_op(MDOp_EX) && calc_div_zero);
            cnt        <= is_div_op(MDOp_EX) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state      <= BUSY;
          end else if (!Flush_EX) begin
            if (MDOp_EX == MD_MTHI) hi <= SrcA_EX;
            if (MDOp_EX == MD_MTLO) lo <= SrcA_EX;
          end
        end
        BUSY: begin
          // Flush and new requests are deliberately ignored until completion.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (pend_write) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a cycle-indexed reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDOp_EX;
  logic        Start_EX, Flush_EX;
  logic [31:0] SrcA_EX, SrcB_EX;
  logic        Busy_MD;
  logic [31:0] HI_out, LO_out, MDout_EX;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .MDOp_EX  (MDOp_EX),
    .Start_EX (Start_EX),
    .Flush_EX (Flush_EX),
    .SrcA_EX  (SrcA_EX),
    .SrcB_EX  (SrcB_EX),
    .Busy_MD  (Busy_MD),
    .HI_out   (HI_out),
    .LO_out   (LO_out),
    .MDout_EX (MDout_EX)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op in cycle c keeps the unit busy through
  // cycle c+N and its result becomes architectural from cycle c+N+1.
  int          cyc = 0;
  bit          m_valid = 0;
  bit          m_busy;
  int          m_done_cyc;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pwrite;

  function automatic bit m_is_start(input logic [3:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction

  function automatic bit m_accept_now();
    return !m_busy && Start_EX && !Flush_EX && m_is_start(MDOp_EX);
  endfunction

  task automatic m_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rhi, output logic [31:0] rlo, output bit wr);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    wr = 1;
    v  = '0;
    case (op)
      MD_MULT:  v = 64'(sa * sb);
      MD_MULTU: begin p = ua * ub; v = p; end
      MD_DIV:   if (b == 0) wr = 0; else begin q = sa / sb; r = sa % sb; v = {r[31:0], q[31:0]}; end
      MD_DIVU:  if (b == 0) wr = 0; else begin p = ua / ub; v[31:0] = p[31:0]; p = ua % ub; v[63:32] = p[31:0]; end
      default:  v = '0;
    endcase
    rhi = v[63:32];
    rlo = v[31:0];
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_busy = 0; m_done_cyc = 0;
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwrite = 0;
    end else if (m_valid) begin
      if (m_busy) begin
        if (cyc == m_done_cyc) begin
          if (m_pwrite) begin m_hi = m_phi; m_lo = m_plo; end
          m_busy = 0;
        end
      end else if (m_accept_now()) begin
        m_compute(MDOp_EX, SrcA_EX, SrcB_EX, m_phi, m_plo, m_pwrite);
        m_busy     = 1;
        m_done_cyc = cyc + ((MDOp_EX == MD_DIV || MDOp_EX == MD_DIVU) ? 10 : 5);
      end else if (!Flush_EX) begin
        if (MDOp_EX == MD_MTHI) m_hi = SrcA_EX;
        if (MDOp_EX == MD_MTLO) m_lo = SrcA_EX;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy", {31'd0, Busy_MD}, {31'd0, m_busy || m_accept_now()});
      check("cyc_hi", HI_out, m_hi);
      check("cyc_lo", LO_out, m_lo);
      check("cyc_mdout", MDout_EX,
            (MDOp_EX == MD_MFHI) ? m_hi : (MDOp_EX == MD_MFLO) ? m_lo : 32'd0);
    end
  end

  task automatic idle_inputs();
    MDOp_EX = MD_NONE; Start_EX = 0; Flush_EX = 0; SrcA_EX = 0; SrcB_EX = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues a start and counts the Busy_MD-high cycles; optionally re-issues a
  // MULT 5*7 start on the second busy cycle, which must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit reissue, output int len);
    MDOp_EX = op; Start_EX = 1; Flush_EX = 0; SrcA_EX = a; SrcB_EX = b;
    len = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!Busy_MD) break;
      len++;
      tick();
      if (reissue && i == 1) begin
        MDOp_EX = MD_MULT; Start_EX = 1; SrcA_EX = 32'd5; SrcB_EX = 32'd7;
      end else begin
        idle_inputs();
      end
    end
    tick();
  endtask

  initial begin
    int len;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    @(negedge clk);
    check("reset_busy", {31'd0, Busy_MD}, 32'd0);
    check("reset_hi", HI_out, 32'd0);
    check("reset_lo", LO_out, 32'd0);
    tick();

    run_op(MD_MULT, 32'd3, 32'hFFFF_FFFE, 0, len);
    check("mult_len", len, 32'd6);
    check("mult_hi", HI_out, 32'hFFFF_FFFF);
    check("mult_lo", LO_out, 32'hFFFF_FFFA);

    run_op(MD_DIVU, 32'd7, 32'd2, 0, len);
    check("divu_len", len, 32'd11);
    check("divu_lo", LO_out, 32'd3);
    check("divu_hi", HI_out, 32'd1);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, len);
    check("div_len", len, 32'd11);
    check("div_lo", LO_out, 32'hFFFF_FFFD);
    check("div_hi", HI_out, 32'hFFFF_FFFF);

    MDOp_EX = MD_MTHI; SrcA_EX = 32'h1234;
    tick();
    idle_inputs();
    check("mthi_hi", HI_out, 32'h1234);

    run_op(MD_DIV, 32'd5, 32'd0, 0, len);
    check("div0_len", len, 32'd11);
    check("div0_hi", HI_out, 32'h1234);
    check("div0_lo", LO_out, 32'hFFFF_FFFD);

    MDOp_EX = MD_MULT; Start_EX = 1; Flush_EX = 1; SrcA_EX = 32'd5; SrcB_EX = 32'd5;
    @(negedge clk);
    check("flush_start_busy", {31'd0, Busy_MD}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("flush_no_busy", {31'd0, Busy_MD}, 32'd0);
    check("flush_hi", HI_out, 32'h1234);
    check("flush_lo", LO_out, 32'hFFFF_FFFD);
    tick();

    MDOp_EX = MD_MTLO; Flush_EX = 1; SrcA_EX = 32'hDEAD;
    tick();
    idle_inputs();
    check("flush_mtlo_lo", LO_out, 32'hFFFF_FFFD);

    MDOp_EX = MD_MFHI;
    @(negedge clk);
    check("mfhi", MDout_EX, 32'h1234);
    tick();
    MDOp_EX = MD_MFLO;
    @(negedge clk);
    check("mflo", MDout_EX, 32'hFFFF_FFFD);
    tick();
    idle_inputs();

    // Reset lands on the edge ending BUSY cycle 3 of a MULTU.
    MDOp_EX = MD_MULTU; Start_EX = 1; SrcA_EX = 32'hFFFF_FFFF; SrcB_EX = 32'd2;
    tick();
    idle_inputs();
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, Busy_MD}, 32'd0);
    check("rst_mid_hi", HI_out, 32'd0);
    check("rst_mid_lo", LO_out, 32'd0);
    repeat (8) tick();
    check("rst_mid_late_hi", HI_out, 32'd0);
    check("rst_mid_late_lo", LO_out, 32'd0);

    run_op(MD_MULT, 32'd2, 32'd3, 1, len);
    check("restart_len", len, 32'd6);
    check("restart_lo", LO_out, 32'd6);
    check("restart_hi", HI_out, 32'd0);
    repeat (12) tick();
    check("restart_late_lo", LO_out, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
